instruction_fetch_responder: RTL and testbench
==============================================

# instruction_fetch_responder

Multi-cycle instruction memory that answers the fetch stage. It accepts a fetch address, returns the instruction word after a fixed number of wait cycles, and drives a stall so the fetch stage and its pipeline register freeze while the access is outstanding. A branch or flush cancels the in-flight access. It sits between the fetch stage's PC output and its instruction input, and it feeds the pipeline freeze logic.

## Interface
Parameters:
- `WAIT_CYCLES`, 3: wait cycles between request acceptance and response; 0 is legal.
- `DEPTH_WORDS`, 1024: storage depth in 32-bit words (power of two).

Ports:
- `clk` input 1: the single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: fetch stage requests the instruction at `req_addr`.
- `req_addr` input `LEN_ADDRESS`: byte address (the current PC).
- `cancel` input 1: branch taken or flush; aborts any in-flight access.
- `load_en` input 1: write enable for the preload port.
- `load_addr` input `LEN_ADDRESS`: byte address for the preload write.
- `load_data` input `LEN_INSTRUCTION`: word to store.
- `instruction` output `LEN_INSTRUCTION`: returned word; valid only while `ready` = 1.
- `ready` output 1: response valid this cycle.
- `stall` output 1: `req_valid & ~ready & ~cancel` (combinational); this drives the fetch freeze.

## Operation
- FSM states:
  - IDLE: no access outstanding.
  - ACCESS: wait counter running.
  - RESP: `ready` = 1 for exactly one cycle.
- Transitions:
  - IDLE → ACCESS on `req_valid & ~cancel`. Latch `req_addr` and load the counter with `WAIT_CYCLES`.
  - IDLE → RESP directly when `WAIT_CYCLES` = 0.
  - ACCESS: decrement the counter each cycle. Go to RESP on the edge where the counter is 1.
  - RESP → IDLE always. No back-to-back acceptance, because the fetch stage advances the PC on the RESP edge.
  - Any state with `cancel` = 1 → IDLE. The counter clears and no response is produced. `cancel` has priority over every other transition.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. The low two bits are ignored. Upper bits beyond the depth wrap (modulo addressing).
- The address is latched at acceptance. Changes to `req_addr` during ACCESS are ignored.
- Storage is read on the edge that enters RESP. `instruction` is registered and held until the next RESP. It is all zeros after reset.
- Preload: `load_en` writes `load_data` at the word index of `load_addr` on the rising edge, in any state.
  - A write and a read of the same word on the same edge returns the old data.
- Storage contents are not cleared by `rst`.

## Timing
- Reset values: state IDLE, counter 0, `ready` 0, `instruction` 0.
- `stall` reset value: equals `req_valid` (combinational, since `ready` = 0).
- A request accepted at edge k gives `ready` = 1 during cycle k+`WAIT_CYCLES`+1, then `ready` = 0 the following cycle.
- Throughput: one fetch per `WAIT_CYCLES`+2 cycles.
- `stall` is 1 from the cycle `req_valid` rises until the RESP cycle, in which it is 0.
- `cancel` in the same cycle as RESP: `ready` is still 1 that cycle, since the output is already registered. The fetch stage discards it because of the flush.
- `cancel` and `req_valid` together in IDLE: the request is not accepted and `stall` = 0. The request is re-presented next cycle.
- `rst` asserted mid-ACCESS or in RESP: the next cycle is IDLE with `ready` = 0 and the access is lost.

## Structure
- `LEN_ADDRESS` and `LEN_INSTRUCTION` come from the shared ISA header.
- FSM state encodings are local parameters inside this block.
- Sub-module `instruction_memory_array`: single-port-read, single-port-write synchronous RAM, `DEPTH_WORDS` × `LEN_INSTRUCTION`.

## Test plan
- **Basic fetch:** preload word 0 = 32'hE3A00005 and word 1 = 32'hE3A01003. Hold `req_valid` with `req_addr` 0, then 4. Expect `ready` pulses in cycles 5 and 10 after reset release, carrying those words in that order. `stall` is high in all other requesting cycles.
- **`WAIT_CYCLES` = 0:** request address 8. Expect `ready` the cycle after acceptance, `stall` high for 1 cycle, and throughput of 1 per 2 cycles.
- **Cancel mid-access:** accept address 0x10, assert `cancel` in the 2nd ACCESS cycle. Expect no `ready` pulse. Next, request 0x40 (preloaded 32'h1234_5678). Expect a response exactly `WAIT_CYCLES`+1 cycles after its acceptance.
- **Address wrap and misalignment:** with `DEPTH_WORDS` = 1024, request 0x1003. Expect the same data as address 0x0.
- **Reset mid-operation:** assert `rst` during ACCESS. Expect IDLE next cycle with `ready` 0 and `instruction` 0. A new request completes normally and the preloaded contents are intact.

Source files
------------

// File: rtl/instruction_fetch_responder_pkg.sv
// Shared ISA widths and word types for the instruction fetch responder slice.
package instruction_fetch_responder_pkg;

    localparam int LEN_ADDRESS     = 32;
    localparam int LEN_INSTRUCTION = 32;

    typedef logic [LEN_ADDRESS-1:0]     addr_t;
    typedef logic [LEN_INSTRUCTION-1:0] instr_t;

endpackage

// File: rtl/instruction_fetch_responder_if.sv
// Fetch-stage handshake: the fetch stage (master) issues PC and cancel,
// the responder (slave) returns the word, a one-cycle ready and the stall.
interface instruction_fetch_responder_if;
    import instruction_fetch_responder_pkg::*;

    logic   req_valid;
    addr_t  req_addr;
    logic   cancel;
    instr_t instruction;
    logic   ready;
    logic   stall;

    modport master (
        output req_valid, req_addr, cancel,
        input  instruction, ready, stall
    );

    modport slave (
        input  req_valid, req_addr, cancel,
        output instruction, ready, stall
    );

endinterface

// File: rtl/instruction_fetch_responder_memory_array.sv
// instruction_memory_array: synchronous RAM with one write port and one
// registered read port; a same-word write and read on one edge returns old data.
module instruction_memory_array
    import instruction_fetch_responder_pkg::*;
#(
    parameter  int DEPTH_WORDS = 1024,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  instr_t           wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output instr_t           rd_data_o
);

    instr_t mem_q [DEPTH_WORDS];
    instr_t rd_data_q;

    // Preload write port, active in every state.
    // NOTE: the storage array has no reset so it maps onto RAM macros and survives rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Registered read; holds the last word until the next read, cleared by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_idx];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instruction_fetch_responder.sv
// Multi-cycle instruction memory answering the fetch stage: accepts a PC,
// returns the word WAIT_CYCLES+1 cycles later and stalls fetch meanwhile.
module instruction_fetch_responder
    import instruction_fetch_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = 3,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    instruction_fetch_responder_if.slave  fetch,
    input  logic                          load_en,
    input  addr_t                         load_addr,
    input  instr_t                        load_data
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(WAIT_CYCLES + 2);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic             ready_q;

    logic             go_resp;
    logic [IDX_W-1:0] rd_idx;
    instr_t           rd_data;

    // Read strobe for the edge entering RESP; with zero wait the read uses the live PC.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        go_resp = 1'b0;
        rd_idx  = idx_q;
        if (state_q == S_IDLE) begin
            rd_idx  = fetch.req_addr[IDX_W+1:2];
            go_resp = fetch.req_valid && !fetch.cancel && (WAIT_CYCLES == 0);
        end else if (state_q == S_ACCESS) begin
            go_resp = !fetch.cancel && (cnt_q == CNT_W'(1));
        end
    end

    // Access FSM with registered ready; cancel beats every transition.
    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else if (fetch.cancel) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b0;
                    if (fetch.req_valid) begin
                        idx_q <= fetch.req_addr[IDX_W+1:2];
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_RESP;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= S_ACCESS;
                            cnt_q   <= WAIT_LOAD;
                        end
                    end
                end
                S_ACCESS: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_RESP;
                        ready_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    instruction_memory_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (load_en),
        .wr_idx    (load_addr[IDX_W+1:2]),
        .wr_data   (load_data),
        .rd_en     (go_resp),
        .rd_idx    (rd_idx),
        .rd_data_o (rd_data)
    );

    // Byte-offset and wrapped upper address bits carry no information here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{fetch.req_addr[LEN_ADDRESS-1:IDX_W+2], fetch.req_addr[1:0],
                                load_addr[LEN_ADDRESS-1:IDX_W+2], load_addr[1:0]};

    assign fetch.instruction = rd_data;
    assign fetch.ready       = ready_q;
    assign fetch.stall       = fetch.req_valid & ~ready_q & ~fetch.cancel;

endmodule

// File: tb/tb_instruction_fetch_responder.sv
// Scoreboard bench: dut_a (WAIT_CYCLES=3) and dut_b (WAIT_CYCLES=0) share
// clock, reset and preload port; a negedge monitor checks every ready pulse.
module tb_instruction_fetch_responder;
    import instruction_fetch_responder_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic   load_en;
    addr_t  load_addr;
    instr_t load_data;
    logic   req_v [2];
    addr_t  req_a [2];
    logic   canc  [2];
    logic   stall_w [2];

    instruction_fetch_responder_if if_a ();
    instruction_fetch_responder_if if_b ();

    assign if_a.req_valid = req_v[0];
    assign if_a.req_addr  = req_a[0];
    assign if_a.cancel    = canc[0];
    assign if_b.req_valid = req_v[1];
    assign if_b.req_addr  = req_a[1];
    assign if_b.cancel    = canc[1];
    assign stall_w[0]     = if_a.stall;
    assign stall_w[1]     = if_b.stall;

    instruction_fetch_responder #(.WAIT_CYCLES(3), .DEPTH_WORDS(1024)) dut_a (
        .clk (clk), .rst (rst), .fetch (if_a),
        .load_en (load_en), .load_addr (load_addr), .load_data (load_data)
    );

    instruction_fetch_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(1024)) dut_b (
        .clk (clk), .rst (rst), .fetch (if_b),
        .load_en (load_en), .load_addr (load_addr), .load_data (load_data)
    );

    typedef struct packed {
        instr_t data;
        int     cyc;
    } exp_t;

    exp_t q_a [$];
    exp_t q_b [$];
    exp_t e_a, e_b;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every ready pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (if_a.ready === 1'b1) begin
            if (q_a.size() == 0) begin
                check("unexpected_ready_a", 32'd1, 32'd0);
            end else begin
                e_a = q_a.pop_front();
                check("data_a", if_a.instruction, e_a.data);
                check("resp_cycle_a", cyc, e_a.cyc);
            end
        end
        if (if_b.ready === 1'b1) begin
            if (q_b.size() == 0) begin
                check("unexpected_ready_b", 32'd1, 32'd0);
            end else begin
                e_b = q_b.pop_front();
                check("data_b", if_b.instruction, e_b.data);
                check("resp_cycle_b", cyc, e_b.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input addr_t addr, input instr_t data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        step();
        load_en   = 1'b0;
    endtask

    // Issue one fetch from IDLE; the response is expected wait cycles after the
    // accepting edge. Returns one cycle after RESP with req_valid still high.
    task automatic fetch(input int d, input addr_t addr, input instr_t exp, input bit cancel_in_resp);
        int wc;
        int acc;
        exp_t e;
        wc       = (d == 0) ? 3 : 0;
        req_v[d] = 1'b1;
        req_a[d] = addr;
        acc      = cyc + 1;
        e.data   = exp;
        e.cyc    = acc + wc;
        if (d == 0) q_a.push_back(e);
        else        q_b.push_back(e);
        #1;
        check("stall_idle_req", stall_w[d], 1'b1);
        for (int c = acc; c <= acc + wc; c++) begin
            step();
            load_en = 1'b0;
            if (c == acc + wc) begin
                if (cancel_in_resp) canc[d] = 1'b1;
                #1;
                check("stall_resp", stall_w[d], 1'b0);
            end else begin
                check("stall_access", stall_w[d], 1'b1);
            end
        end
        step();
        canc[d] = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0;
            req_a[i] = '0;
            canc[i]  = 1'b0;
        end
        repeat (2) step();

        // Preload while reset is held; storage writes are independent of rst.
        load(32'h0000_0000, 32'hE3A0_0005);
        load(32'h0000_0004, 32'hE3A0_1003);
        load(32'h0000_0008, 32'hA5A5_0008);
        load(32'h0000_0010, 32'hDEAD_BEEF);
        load(32'h0000_0040, 32'h1234_5678);

        // Reset state; stall follows req_valid while ready is low.
        req_v[0] = 1'b1;
        req_a[0] = 32'h0;
        #1;
        check("reset_ready_a", if_a.ready, 1'b0);
        check("reset_instr_a", if_a.instruction, 32'h0);
        check("reset_stall_a", if_a.stall, 1'b1);
        check("reset_ready_b", if_b.ready, 1'b0);
        check("reset_instr_b", if_b.instruction, 32'h0);
        check("reset_stall_b", if_b.stall, 1'b0);

        // Basic fetch: two back-to-back requests, pulses 5 cycles apart.
        rst = 1'b0;
        fetch(0, 32'h0, 32'hE3A0_0005, 1'b0);
        fetch(0, 32'h4, 32'hE3A0_1003, 1'b0);
        req_v[0] = 1'b0;
        step();

        // Zero wait cycles: response one cycle after acceptance, one fetch per 2 cycles.
        fetch(1, 32'h8, 32'hA5A5_0008, 1'b0);
        fetch(1, 32'h8, 32'hA5A5_0008, 1'b0);
        // Same-word write on the read edge returns the old word; cancel in RESP keeps ready.
        load_en   = 1'b1;
        load_addr = 32'h8;
        load_data = 32'h0BAD_F00D;
        fetch(1, 32'h8, 32'hA5A5_0008, 1'b1);
        fetch(1, 32'h8, 32'h0BAD_F00D, 1'b0);
        req_v[1] = 1'b0;
        step();

        // Cancel in the 2nd ACCESS cycle: no response may appear.
        req_v[0] = 1'b1;
        req_a[0] = 32'h10;
        step();
        step();
        canc[0] = 1'b1;
        #1;
        check("stall_cancel_access", stall_w[0], 1'b0);
        step();
        canc[0]  = 1'b0;
        req_v[0] = 1'b0;
        repeat (4) step();

        // Cancel with request in IDLE: not accepted, stall low, re-presented next cycle.
        canc[0]  = 1'b1;
        req_v[0] = 1'b1;
        req_a[0] = 32'h40;
        #1;
        check("stall_cancel_idle", stall_w[0], 1'b0);
        step();
        canc[0] = 1'b0;
        fetch(0, 32'h40, 32'h1234_5678, 1'b0);

        // Misaligned address beyond the depth wraps onto word 0.
        fetch(0, 32'h1003, 32'hE3A0_0005, 1'b1);
        req_v[0] = 1'b0;
        step();

        // Reset mid-ACCESS: access lost, outputs cleared, storage intact.
        req_v[0] = 1'b1;
        req_a[0] = 32'h4;
        step();
        step();
        rst      = 1'b1;
        req_v[0] = 1'b0;
        step();
        rst = 1'b0;
        check("rst_mid_ready", if_a.ready, 1'b0);
        check("rst_mid_instr", if_a.instruction, 32'h0);
        repeat (5) step();
        fetch(0, 32'h4, 32'hE3A0_1003, 1'b0);
        fetch(0, 32'h40, 32'h1234_5678, 1'b0);
        req_v[0] = 1'b0;
        repeat (6) step();

        check("pending_resp_a", q_a.size(), 32'd0);
        check("pending_resp_b", q_b.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
